// File: rtl/sdatamem_hs.sv
// Handshaked data memory: byte-enabled synchronous-read array, sign/zero-extended loads, error responses.
// Define SDATAMEM_MISALIGN_EN to allow misaligned and word-crossing accesses.
module sdatamem_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BPW);
  localparam int WORDS = MEM_BYTES / BPW;
  localparam int IDXW  = $clog2(WORDS);
  localparam int AW    = OFFW + IDXW;
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH+1)'(MEM_BYTES);

  typedef enum logic [2:0] {
    IDLE, ACC_LO, ACC_HI, RDWAIT, RESP
  } state_t;

  state_t                r_state;
  logic                  r_write;
  logic                  r_uns;
  logic                  r_err;
  logic                  r_rsp_err;
  logic [1:0]            r_size;
  logic [AW-1:0]         r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [DATA_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  logic                    w_accept;
  logic [3:0]              w_req_n;
  logic                    w_oob;
  logic                    w_ill;
  logic                    w_mis;
  logic                    w_err;
  logic [3:0]              w_n;
  logic [OFFW-1:0]         w_off;
  logic [IDXW-1:0]         w_idx;
  logic [IDXW-1:0]         w_widx;
  logic                    w_cross;
  logic                    w_hi;
  logic                    w_we;
  logic [BPW-1:0]          w_bmask;
  logic [2*BPW-1:0]        w_bsh;
  logic [2*DATA_WIDTH-1:0] w_wsh;
  logic [BPW-1:0]          w_be;
  logic [DATA_WIDTH-1:0]   w_wd;
  logic [DATA_WIDTH-1:0]   w_rsel;
  logic [DATA_WIDTH-1:0]   w_ext;
  logic                    w_sign;

  assign req_ready_o = !rst && (r_state == IDLE ||
                       (r_state == RESP && rsp_ready_i));
  assign w_accept    = req_valid_i && req_ready_o;
  assign rsp_valid_o = (r_state == RESP);
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_rsp_err;

  assign w_req_n = 4'd1 << req_size_i;
  assign w_oob   = ({1'b0, req_addr_i} +
                    {{(ADDR_WIDTH-3){1'b0}}, w_req_n}) > LIM;
  assign w_ill   = (DATA_WIDTH == 32) && (req_size_i == 2'b11);
  assign w_n     = 4'd1 << r_size;
  assign w_off   = r_addr[OFFW-1:0];
  assign w_idx   = r_addr[AW-1:OFFW];

`ifdef SDATAMEM_MISALIGN_EN
  assign w_mis   = 1'b0;
  assign w_cross = (5'(w_off) + 5'(w_n)) > 5'(BPW);
`else
  assign w_mis   = (req_addr_i[2:0] & 3'(w_req_n - 4'd1)) != 3'd0;
  assign w_cross = 1'b0;
`endif

  assign w_err = w_oob || w_ill || w_mis;

  // Store data/enables are laid out over two words; the high half
  // only matters for accesses that spill into the next word.
  assign w_hi   = (r_state == ACC_HI);
  assign w_widx = w_idx + IDXW'(w_hi);
  assign w_we   = !rst && r_write &&
                  (r_state == ACC_LO || w_hi);
  assign w_wsh  = {{DATA_WIDTH{1'b0}}, r_wdata} << {w_off, 3'b000};
  assign w_bsh  = {{BPW{1'b0}}, w_bmask} << w_off;
  assign w_be   = w_hi ? w_bsh[2*BPW-1:BPW] : w_bsh[BPW-1:0];
  assign w_wd   = w_hi ? w_wsh[2*DATA_WIDTH-1:DATA_WIDTH]
                       : w_wsh[DATA_WIDTH-1:0];
  assign w_rsel = DATA_WIDTH'({r_rd, (w_cross ? r_lo : r_rd)}
                  >> {w_off, 3'b000});

  always_comb begin
    w_bmask = '0;
    w_sign  = 1'b0;
    w_ext   = '0;
    for (int b = 0; b < BPW; b++) begin
      w_bmask[b] = (b < int'(w_n));
      if (b == int'(w_n) - 1) w_sign = w_rsel[8*b+7];
    end
    for (int b = 0; b < BPW; b++) begin
      w_ext[8*b +: 8] = (b < int'(w_n)) ? w_rsel[8*b +: 8]
                        : {8{w_sign & ~r_uns}};
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < BPW; b++) begin
      if (w_we && w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wd[8*b +: 8];
    end
    r_rd <= r_mem[w_widx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rdata   <= '0;
      r_rsp_err <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            r_write <= req_write_i;
            r_size  <= req_size_i;
            r_uns   <= req_unsigned_i;
            r_addr  <= req_addr_i[AW-1:0];
            r_wdata <= req_wdata_i;
            r_err   <= w_err;
            // Errors still pass through RDWAIT to register the response
            r_state <= w_err ? RDWAIT : ACC_LO;
          end else if (r_state == RESP && rsp_ready_i) begin
            r_state <= IDLE;
          end
        end
        ACC_LO: r_state <= w_cross ? ACC_HI : RDWAIT;
        ACC_HI: begin
          r_lo    <= r_rd;
          r_state <= RDWAIT;
        end
        RDWAIT: begin
          r_rdata   <= (r_err || r_write) ? '0 : w_ext;
          r_rsp_err <= r_err;
          r_state   <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdatamem_hs.sv
// Randomized bench for sdatamem_hs with a byte-array reference model
// and a per-cycle compare process; directed cases pin the model.
module tb_sdatamem_hs;

  localparam int DW  = 32;
  localparam int MB  = 4096;
  localparam int AW  = 32;
  localparam int BPW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_write_i;
  logic [1:0]    req_size_i;
  logic          req_unsigned_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;

  sdatamem_hs #(.DATA_WIDTH(DW), .MEM_BYTES(MB), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_write_i    (req_write_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    bit            wr;
    int            addr;
    int            n;
    logic [DW-1:0] wdata;
  } exp_t;

  int   checks   = 0;
  int   failures = 0;
  int   cnt      = 0;
  int   accs     = 0;
  int   pops     = 0;
  logic rst_prev = 1'b1;
  exp_t q[$];
  exp_t last_exp;
  logic [7:0] mm [MB];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(bit w, logic [1:0] sz, bit u,
                                 logic [AW-1:0] a, logic [DW-1:0] d);
    exp_t        e;
    int          n;
    longint      ua;
    logic [63:0] v;
    n  = 1 << sz;
    ua = longint'(a);
    e.wr = w; e.n = n; e.wdata = d; e.rdata = '0; e.addr = 0;
    e.err = (ua + n > MB) || (sz == 2'b11 && DW == 32);
`ifndef SDATAMEM_MISALIGN_EN
    if (ua % n != 0) e.err = 1'b1;
`endif
    if (e.err) begin
      e.lat = 1;
      return e;
    end
    e.addr = int'(ua);
    e.lat  = ((e.addr % BPW) + n > BPW) ? 3 : 2;
    if (!w) begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mm[e.addr + i];
      if (!u && v[8*n-1])
        for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
      e.rdata = v[DW-1:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t h;
    bit   ev;
    if (rst) begin
      if (rst_prev) begin
        chk("rst_valid", rsp_valid_o, 0);
        chk("rst_err", rsp_err_o, 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        chk("rst_ready", req_ready_o, 0);
      end
      q.delete();
      cnt = 0;
    end else begin
      if (rst_prev) chk("ready_after_rst", req_ready_o, 1);
      if (q.size() > 0) cnt++;
      ev = (q.size() > 0) && (cnt > q[0].lat);
      chk("rsp_valid", rsp_valid_o, ev);
      chk("req_ready", req_ready_o,
          (q.size() == 0) || (ev && rsp_ready_i));
      if (ev) begin
        h = q[0];
        chk("rsp_rdata", rsp_rdata_o, h.rdata);
        chk("rsp_err", rsp_err_o, h.err);
        if (rsp_ready_i) begin
          if (h.wr && !h.err)
            for (int i = 0; i < h.n; i++)
              mm[h.addr + i] = h.wdata[8*i +: 8];
          last_exp = h;
          void'(q.pop_front());
          pops++;
        end
      end
      if (req_valid_i && req_ready_o) begin
        q.push_back(model(req_write_i, req_size_i, req_unsigned_i,
                          req_addr_i, req_wdata_i));
        cnt = 0;
        accs++;
      end
    end
    rst_prev = rst;
  end

  task automatic send(bit w, logic [1:0] sz, bit u,
                      logic [AW-1:0] a, logic [DW-1:0] d);
    int a0, p0;
    a0 = accs;
    p0 = pops;
    req_write_i = w; req_size_i = sz; req_unsigned_i = u;
    req_addr_i = a; req_wdata_i = d;
    req_valid_i = 1'b1; rsp_ready_i = 1'b1;
    for (int k = 0; k < 20 && accs == a0; k++) begin
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    chk("accept_timeout", accs != a0, 1);
    for (int k = 0; k < 20 && pops == p0; k++) begin
      @(posedge clk); #1;
    end
    chk("rsp_timeout", pops != p0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int a0, p0, r;
    req_valid_i = 0; req_write_i = 0; req_size_i = 0;
    req_unsigned_i = 0; req_addr_i = 0; req_wdata_i = 0;
    rsp_ready_i = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int a = 0; a < 80; a += 4)
      send(1, 2, 0, AW'(a), {16'hA5A5, 16'(a)});
    for (int a = MB - 64; a < MB; a += 4)
      send(1, 2, 0, AW'(a), {16'hA5A5, 16'(a)});

    send(1, 2, 0, 'h10, 32'hDEADBEEF);
    send(0, 2, 0, 'h10, 0);
    chk("ld_word", last_exp.rdata, 32'hDEADBEEF);
    chk("ld_word_err", last_exp.err, 0);
    chk("ld_word_lat", last_exp.lat, 2);
    send(0, 0, 0, 'h13, 0);
    chk("ld_byte_s", last_exp.rdata, 32'hFFFFFFDE);
    send(0, 0, 1, 'h13, 0);
    chk("ld_byte_u", last_exp.rdata, 32'h000000DE);
    send(0, 1, 0, 'h12, 0);
    chk("ld_half_s", last_exp.rdata, 32'hFFFFDEAD);

    send(0, 2, 0, AW'(MB - 2), 0);
    chk("oob_ld_err", last_exp.err, 1);
    chk("oob_ld_rdata", last_exp.rdata, 0);
    chk("oob_ld_lat", last_exp.lat, 1);
    send(1, 2, 0, AW'(MB - 2), 32'h12345678);
    chk("oob_st_err", last_exp.err, 1);
    send(0, 2, 0, AW'(MB - 4), 0);
    chk("oob_st_intact", last_exp.rdata, 32'hA5A50FFC);

    send(1, 2, 0, 'h14, 32'h11223344);
    send(0, 2, 0, 'h12, 0);
`ifdef SDATAMEM_MISALIGN_EN
    chk("mis_rdata", last_exp.rdata, 32'h3344DEAD);
    chk("mis_lat", last_exp.lat, 3);
`else
    chk("mis_err", last_exp.err, 1);
    chk("mis_lat", last_exp.lat, 1);
`endif

    // backpressure, then accept a new request on the consuming edge
    a0 = accs;
    rsp_ready_i = 0;
    req_write_i = 0; req_size_i = 2; req_unsigned_i = 0;
    req_addr_i = 'h10; req_valid_i = 1;
    for (int k = 0; k < 20 && accs == a0; k++) begin
      @(posedge clk); #1;
    end
    req_valid_i = 0;
    for (int k = 0; k < 20 && !rsp_valid_o; k++) begin
      @(posedge clk); #1;
    end
    repeat (5) begin
      @(negedge clk);
      chk("hold_ready", req_ready_o, 0);
      chk("hold_valid", rsp_valid_o, 1);
      chk("hold_rdata", rsp_rdata_o, 32'hDEADBEEF);
    end
    @(posedge clk); #1;
    p0 = pops;
    a0 = accs;
    req_size_i = 0; req_unsigned_i = 1; req_addr_i = 'h14;
    req_valid_i = 1; rsp_ready_i = 1;
    @(negedge clk);
    chk("same_edge_ready", req_ready_o, 1);
    @(posedge clk); #1;
    req_valid_i = 0;
    chk("same_edge_accept", accs - a0, 1);
    for (int k = 0; k < 20 && pops < p0 + 2; k++) begin
      @(posedge clk); #1;
    end
    chk("same_edge_rdata", last_exp.rdata, 32'h00000044);

    // reset lands on the write edge of a store
    a0 = accs;
    req_write_i = 1; req_size_i = 2; req_addr_i = 'h20;
    req_wdata_i = 32'hCAFEF00D; req_valid_i = 1;
    for (int k = 0; k < 20 && accs == a0; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    req_valid_i = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(0, 2, 0, 'h20, 0);
    chk("rst_store_intact", last_exp.rdata, 32'hA5A50020);

    repeat (3000) begin
      @(posedge clk); #1;
      r = $urandom_range(0, 7);
      req_valid_i    = 1'($urandom_range(0, 1));
      req_write_i    = 1'($urandom_range(0, 1));
      req_size_i     = 2'($urandom_range(0, 3));
      req_unsigned_i = 1'($urandom_range(0, 1));
      req_wdata_i    = $urandom;
      if (r == 0)      req_addr_i = $urandom;
      else if (r < 4)  req_addr_i = AW'(MB - 64 + $urandom_range(0, 63));
      else             req_addr_i = AW'($urandom_range(0, 63));
      rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
    req_valid_i = 0;
    rsp_ready_i = 1;
    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
